// File: rtl/nn_seq_pkg.sv
// Shared types and default sizing for the layer sequencer.
// Defaults describe a 256-pixel input layer and 15-node hidden layers, each with a bias row.
package nn_seq_pkg;

  localparam int DEF_INPUT_CYCLES  = 257;
  localparam int DEF_HIDDEN_CYCLES = 16;
  localparam int DEF_ADR_LEN       = 9;
  localparam int MAX_LAYERS        = 4;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    MAC,
    WRITE,
    DONE
  } seq_state_t;

endpackage

// File: rtl/seq_counter.sv
// Row-address counter for the MAC phase of each layer.
// It flags the row that ends the current layer.
module seq_counter
  import nn_seq_pkg::*;
#(
  parameter int ADR_LEN = DEF_ADR_LEN
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_clear,
  input  logic               i_enable,
  input  logic [ADR_LEN-1:0] i_termVal,
  output logic [ADR_LEN-1:0] o_count,
  output logic               o_terminal
);

  logic [ADR_LEN-1:0] r_count;

  // Clear wins over enable, so the terminal row returns the count to zero instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + ADR_LEN'(1);
    end
  end

  assign o_count    = r_count;
  assign o_terminal = (r_count == i_termVal);

endmodule

// File: rtl/layer_sequencer.sv
// Steps an inference through CLEAR/MAC/WRITE for each weight layer.
// Optional macro LAYER_SEQ_STALL_EN: layer-0 MAC rows stall while img_valid is low.
module layer_sequencer
  import nn_seq_pkg::*;
#(
  parameter int NUM_LAYERS    = 3,
  parameter int INPUT_CYCLES  = DEF_INPUT_CYCLES,
  parameter int HIDDEN_CYCLES = DEF_HIDDEN_CYCLES,
  parameter int ADR_LEN       = DEF_ADR_LEN
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               img_valid,
  output logic [ADR_LEN-1:0] cycle,
  output logic               clear,
  output logic               acc_en,
  output logic               we,
  output logic               rd_src1,
  output logic [1:0]         rd_src2,
  output logic               busy,
  output logic               done
);

  localparam logic [1:0]         LAST_LAYER  = 2'(NUM_LAYERS - 1);
  localparam logic [ADR_LEN-1:0] INPUT_TERM  = ADR_LEN'(INPUT_CYCLES - 1);
  localparam logic [ADR_LEN-1:0] HIDDEN_TERM = ADR_LEN'(HIDDEN_CYCLES - 1);

  seq_state_t         r_state;
  seq_state_t         w_stateNext;
  logic [1:0]         r_layer;
  logic [1:0]         w_layerNext;
  logic               w_advance;
  logic               w_terminal;
  logic               w_cntClear;
  logic [ADR_LEN-1:0] w_termVal;
  logic [ADR_LEN-1:0] w_count;

`ifdef LAYER_SEQ_STALL_EN
  assign w_advance = (r_state == MAC) && ((r_layer != 2'd0) || img_valid);
`else
  logic w_unusedImgValid;
  assign w_unusedImgValid = img_valid;
  assign w_advance        = (r_state == MAC);
`endif

  assign w_termVal  = (r_layer == 2'd0) ? INPUT_TERM : HIDDEN_TERM;
  // Holding the counter cleared outside MAC keeps cycle at zero in every other state.
  assign w_cntClear = (r_state != MAC) || (w_advance && w_terminal);

  seq_counter #(
    .ADR_LEN (ADR_LEN)
  ) u_counter (
    .clk        (clk),
    .reset      (reset),
    .i_clear    (w_cntClear),
    .i_enable   (w_advance),
    .i_termVal  (w_termVal),
    .o_count    (w_count),
    .o_terminal (w_terminal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_layer <= 2'd0;
    end else begin
      r_state <= w_stateNext;
      r_layer <= w_layerNext;
    end
  end

  // The accumulator stays cleared while idle, so clear is high in IDLE as well as in CLEAR.
  always_comb begin
    w_stateNext = r_state;
    w_layerNext = r_layer;
    clear       = 1'b0;
    acc_en      = 1'b0;
    we          = 1'b0;
    busy        = 1'b1;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        busy        = 1'b0;
        clear       = 1'b1;
        w_layerNext = 2'd0;
        if (start) begin
          w_stateNext = CLEAR;
        end
      end
      CLEAR: begin
        clear       = 1'b1;
        w_stateNext = MAC;
      end
      MAC: begin
        acc_en = w_advance;
        if (w_advance && w_terminal) begin
          w_stateNext = WRITE;
        end
      end
      WRITE: begin
        we = 1'b1;
        if (r_layer == LAST_LAYER) begin
          w_layerNext = 2'd0;
          w_stateNext = DONE;
        end else begin
          w_layerNext = r_layer + 2'd1;
          w_stateNext = CLEAR;
        end
      end
      DONE: begin
        done        = 1'b1;
        w_stateNext = IDLE;
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  assign cycle   = w_count;
  assign rd_src1 = (r_layer != 2'd0);
  assign rd_src2 = r_layer;

endmodule
